// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the L1 I-cache (read-only) and the L1 D-cache.
// The command is latched at grant, and completion is returned only to the owner.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_last;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_d;
  logic w_grant_wr;
  logic w_done;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Next state and grant decision; on a tie the side that did not finish last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_grant_wr  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_req || w_d_req) begin
          w_grant     = 1'b1;
          w_grant_d   = w_d_req && (!w_i_req || !r_last);
          w_grant_wr  = w_grant_d && d_write;
          w_state_nxt = S_SERVE;
        end
      end
      S_SERVE: begin
        if (mem_resp) begin
          w_done      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latched command and ownership bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_owner     <= w_grant_d;
        r_mem_read  <= !w_grant_wr;
        r_mem_write <= w_grant_wr;
        r_addr      <= w_grant_d ? d_address : i_address;
        r_wdata     <= w_grant_d ? d_wdata : '0;
      end else if (w_done) begin
        r_last      <= r_owner;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = r_busy;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign i_resp      = w_done && !r_owner;
  assign d_resp      = w_done && r_owner;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a table of single transactions, then reset-abort and held-contention sequences.
module tb_cache_mem_arbiter;
  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          busy;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  typedef struct {
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    int unsigned   lat;
    logic          e_rd, e_wr, e_d;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
  } vec_t;

  typedef struct {
    logic          d;
    logic [LW-1:0] data;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Check the command in the first SERVE cycle; optionally record the expected completion.
  task automatic expect_cmd(input string tag, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [LW-1:0] wd,
                            input logic d, input logic push);
    sb_t e;
    chk({tag, "_mem_read"},  LW'(mem_read), LW'(rd));
    chk({tag, "_mem_write"}, LW'(mem_write), LW'(wr));
    chk({tag, "_mem_addr"},  LW'(mem_address), LW'(a));
    chk({tag, "_mem_wdata"}, mem_wdata, wd);
    chk({tag, "_busy"},      LW'(busy), LW'(1'b1));
    if (push) begin
      e.d    = d;
      e.data = rand_line();
      sb_q.push_back(e);
    end
  endtask

  // Drive mem_resp with the scoreboard's data and check the routed pulse.
  task automatic issue_resp(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", tag);
      e.d    = 1'b0;
      e.data = '0;
    end else begin
      e = sb_q.pop_front();
    end
    mem_rdata = e.data;
    mem_resp  = 1'b1;
    #1;
    chk({tag, "_i_resp"}, LW'(i_resp), LW'(!e.d));
    chk({tag, "_d_resp"}, LW'(d_resp), LW'(e.d));
    chk({tag, "_rdata"},  e.d ? d_rdata : i_rdata, e.data);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", n);
    chk({tag, "_idle_busy"}, LW'(busy), LW'(1'b0));
    i_read = v.ir; d_read = v.dr; d_write = v.dw;
    i_address = v.ia; d_address = v.da; d_wdata = v.wd;
    tick();
    expect_cmd(tag, v.e_rd, v.e_wr, v.e_addr, v.e_wd, v.e_d, 1'b1);
    i_address = 32'hDEAD_0000; d_address = 32'h0000_3000; d_wdata = ~v.wd;
    for (int c = 0; c < int'(v.lat); c++) begin
      tick();
      chk({tag, "_wait_addr"}, LW'(mem_address), LW'(v.e_addr));
      chk({tag, "_wait_resp"}, LW'({i_resp, d_resp}), LW'(2'b00));
    end
    issue_resp(tag);
    chk({tag, "_held_addr"}, LW'(mem_address), LW'(v.e_addr));
    chk({tag, "_held_wdata"}, mem_wdata, v.e_wd);
    tick();
    // mem_resp is left high through DONE: it must be ignored there.
    chk({tag, "_done_resp"}, LW'({i_resp, d_resp}), LW'(2'b00));
    chk({tag, "_done_cmd"},  LW'({mem_read, mem_write}), LW'(2'b00));
    chk({tag, "_done_busy"}, LW'(busy), LW'(1'b1));
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick();
    mem_resp = 1'b0;
    chk({tag, "_end_busy"}, LW'(busy), LW'(1'b0));
  endtask

  // Both sides held: serve one transaction with zero-wait memory and return to IDLE.
  task automatic serve_held(input string tag, input logic d, input logic [AW-1:0] a,
                            input logic [LW-1:0] wd);
    tick();
    expect_cmd(tag, 1'b1, 1'b0, a, wd, d, 1'b1);
    issue_resp(tag);
    tick();
    mem_resp = 1'b0;
    chk({tag, "_done_cmd"}, LW'({mem_read, mem_write}), LW'(2'b00));
    tick();
    chk({tag, "_idle_busy"}, LW'(busy), LW'(1'b0));
  endtask

  initial begin
    logic [LW-1:0] p55, paa, p33, pcc, p77;
    p55 = {8{32'h5555_5555}};
    paa = {8{32'hAAAA_AAAA}};
    p33 = {8{32'h3333_3333}};
    pcc = {8{32'hCCCC_CCCC}};
    p77 = {8{32'h7777_7777}};
    //          ir    dr    dw    ia            da            wd   lat  rd    wr    d     addr          wdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, '0,  2, 1'b1, 1'b0, 1'b0, 32'h0000_1000, '0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_2040, p55, 1, 1'b0, 1'b1, 1'b1, 32'h0000_2040, p55};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_1100, 32'h0000_2100, paa, 0, 1'b1, 1'b0, 1'b0, 32'h0000_1100, '0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_1200, 32'h0000_2200, p33, 1, 1'b1, 1'b0, 1'b1, 32'h0000_2200, p33};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_2300, pcc, 0, 1'b0, 1'b1, 1'b1, 32'h0000_2300, pcc};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_1400, 32'h0000_2400, p55, 2, 1'b1, 1'b0, 1'b0, 32'h0000_1400, '0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_1500, 32'h0000_2500, p77, 0, 1'b0, 1'b1, 1'b1, 32'h0000_2500, p77};

    reset_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    #2;
    chk("rst_cmd",   LW'({mem_read, mem_write}), LW'(2'b00));
    chk("rst_addr",  LW'(mem_address), LW'(0));
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_resp",  LW'({i_resp, d_resp}), LW'(2'b00));
    chk("rst_busy",  LW'(busy), LW'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // Spurious mem_resp while idle.
    mem_resp = 1'b1;
    mem_rdata = paa;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("spur_idle_resp", LW'({i_resp, d_resp}), LW'(2'b00));
      tick();
      chk("spur_idle_busy", LW'(busy), LW'(1'b0));
      chk("spur_idle_cmd",  LW'({mem_read, mem_write}), LW'(2'b00));
    end
    mem_resp = 1'b0;

    // Reset in SERVE abandons the transaction; both requests stay held afterwards.
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000; d_wdata = p33;
    tick();
    expect_cmd("abort", 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0);
    mem_resp = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("abort_cmd",  LW'({mem_read, mem_write}), LW'(2'b00));
    chk("abort_resp", LW'({i_resp, d_resp}), LW'(2'b00));
    chk("abort_busy", LW'(busy), LW'(1'b0));
    chk("abort_addr", LW'(mem_address), LW'(0));
    tick();
    reset_n = 1'b1;
    mem_resp = 1'b0;

    serve_held("rr0_i", 1'b0, 32'h0000_1000, '0);
    serve_held("rr1_d", 1'b1, 32'h0000_2000, p33);
    serve_held("rr2_i", 1'b0, 32'h0000_1000, '0);
    i_read = 1'b0; d_read = 1'b0;
    tick();
    tick();
    chk("final_busy", LW'(busy), LW'(1'b0));
    chk("sb_drain",   LW'(sb_q.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single 256-bit physical-memory / write-buffer port between the L1 instruction cache (read-only) and the L1 data cache (read/write). It grants the port to one requester at a time and uses round-robin priority on contention. On grant it latches that requester's command, so downstream sees a stable request. It forwards the downstream response back to the granted requester only.

## Interface
- LINE_WIDTH, 256, cache-line / data width in bits
- ADDR_WIDTH, 32, address width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request; level, held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  read data to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read, d_write  in  1 each  D-cache request; level, held until d_resp
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache writeback data
- d_rdata  out  LINE_WIDTH  read data to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read, mem_write  out  1 each  downstream command
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  LINE_WIDTH  downstream write data
- mem_rdata  in  LINE_WIDTH  downstream read data
- mem_resp  in  1  downstream completion, valid only while a command is asserted
- busy  out  1  high in SERVE and DONE

## Operation
- States:
  - IDLE: no command driven; arbitration evaluated every cycle.
  - SERVE: owner's command driven.
  - DONE: one bubble cycle; no command, no grant.
- Internal registers:
  - owner: 0 = I, 1 = D.
  - last: owner of the last completed transaction.
  - Latched op (read or write), addr, wdata.
- Arbitration in IDLE:
  - Only I requesting: grant I.
  - Only D requesting: grant D.
  - Both requesting: grant the side not equal to last.
  - Nothing requesting: stay in IDLE.
  - d_read and d_write both high is a protocol violation; it is treated as a write.
- On grant:
  - Latch owner, op, address and wdata. I grants latch wdata = 0.
  - Go to SERVE.
- SERVE:
  - mem_read = (op == read), mem_write = (op == write).
  - mem_address and mem_wdata come from the latched registers.
  - Requester inputs are ignored. Deasserting or changing them has no effect on the transaction in flight.
- On mem_resp in SERVE:
  - Owner's resp = 1 in the same cycle (combinational); the other side's resp = 0.
  - last <= owner; next state DONE.
- DONE → IDLE unconditionally. The bubble lets the requester's FSM drop its request before the next arbitration.
- i_rdata = d_rdata = mem_rdata at all times (broadcast). Only the resp pulses are gated.
- mem_resp in IDLE or DONE is ignored: no resp pulse, no state change.
- Reset (asynchronous, immediate):
  - State = IDLE, owner = 0, last = 1 (I wins the first tie).
  - Latched addr and wdata = 0.
  - mem_read = mem_write = 0, mem_address = 0, mem_wdata = 0.
  - i_resp = d_resp = 0, busy = 0.
  - Reset during SERVE abandons the downstream transaction; no resp is ever issued for it.

## Timing
- Request high during cycle 0 → grant at end of cycle 0 → command asserted from cycle 1.
- mem_resp in cycle k → resp pulse in cycle k → DONE in k+1 → IDLE in k+2.
- Earliest next command is cycle k+3.
- Zero-wait downstream (mem_resp in cycle 1): 4-cycle occupancy per transaction.
- Command outputs are registered and glitch-free. The resp outputs are combinational from mem_resp and state.
- Fairness bound under continuous contention: a waiting requester is served after at most one transaction of the other side.

## Test plan
- Single I read at 0x0000_1000:
  - mem_read high from cycle 1.
  - mem_resp at cycle 3 with data 0xAA…AA → i_resp = 1 at cycle 3 with i_rdata = 0xAA…AA; d_resp stays 0.
  - busy falls at cycle 5.
- D write to 0x0000_2040 with wdata 0x55…55:
  - mem_write = 1, mem_address = 0x0000_2040, mem_wdata = 0x55…55 held until mem_resp.
  - d_resp pulses exactly once.
- Simultaneous i_read and d_read from reset, both held:
  - I is served first, then D, then I.
  - Grants alternate; neither side waits for more than one of the other's transactions.
- D requester changes d_address to 0x0000_3000 mid-SERVE:
  - mem_address stays at the latched 0x0000_2040 until completion.
- Spurious mem_resp in IDLE, and again in DONE:
  - No resp pulse, no state change.
- reset_n asserted low during SERVE:
  - mem_read and mem_write drop to 0 immediately with no resp pulse.
  - After release, a pending i_read and d_read go to I first.
